// File: rtl/rst_seq_if.sv
// rtl/rst_seq_if.sv - request/status bundle between a reset requester and rst_seq
interface rst_seq_if #(
  parameter int NUM_DOMAINS = 4
);
  logic                   sw_rst_req;
  logic                   hold;
  logic [NUM_DOMAINS-1:0] dom_rst_;
  logic                   busy;
  logic                   all_released;
  logic                   sw_rst_ack;
  logic                   wdog_err;

  modport master (
    output sw_rst_req, hold,
    input  dom_rst_, busy, all_released, sw_rst_ack, wdog_err
  );

  modport slave (
    input  sw_rst_req, hold,
    output dom_rst_, busy, all_released, sw_rst_ack, wdog_err
  );
endinterface

// File: rtl/rst_seq.sv
// rtl/rst_seq.sv - staged reset-domain sequencer; hold watchdog enabled by RST_SEQ_WDOG_EN
module rst_seq #(
  parameter int NUM_DOMAINS  = 4,
  parameter int STAGE_CYCLES = 16,
  parameter int WDOG_CYCLES  = 1024
) (
  input  logic       clk,
  input  logic       rst_,
  rst_seq_if.slave   bus
);
  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(STAGE_CYCLES - 1);
  localparam logic [3:0]  IDX_LAST = 4'(NUM_DOMAINS - 1);

  state_t                 state_q, state_d;
  logic [15:0]            cnt_q, cnt_d;
  logic [3:0]             idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   busy_q, busy_d;
  logic                   all_rel_q, all_rel_d;
  logic                   ack_q, ack_d;
  logic                   ack_pend_q, ack_pend_d;

  // State register: sequencer state, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= ST_ASSERT;
      cnt_q      <= '0;
      idx_q      <= '0;
      dom_q      <= '0;
      busy_q     <= 1'b1;
      all_rel_q  <= 1'b0;
      ack_q      <= 1'b0;
      ack_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dom_q      <= dom_d;
      busy_q     <= busy_d;
      all_rel_q  <= all_rel_d;
      ack_q      <= ack_d;
      ack_pend_q <= ack_pend_d;
    end
  end

  // Next state: software request or hold restarts; otherwise one domain per stage
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    if (bus.sw_rst_req) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (bus.hold) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            dom_d   = NUM_DOMAINS'(1);
            idx_d   = 4'd1;
            state_d = (NUM_DOMAINS == 1) ? ST_DONE : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_RELEASE: begin
          if (bus.hold) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            idx_d   = '0;
            dom_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            dom_d = dom_q | (NUM_DOMAINS'(1) << idx_q);
            idx_d = idx_q + 4'd1;
            if (idx_q == IDX_LAST) begin
              state_d = ST_DONE;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          cnt_d = '0;
          if (bus.hold) begin
            state_d = ST_ASSERT;
            idx_d   = '0;
            dom_d   = '0;
          end
        end
      endcase
    end
  end

  // Outputs: status follows next state; ack fires once on DONE entry if a request is owed
  always_comb begin
    busy_d     = (state_d != ST_DONE);
    all_rel_d  = (state_d == ST_DONE);
    ack_d      = 1'b0;
    ack_pend_d = ack_pend_q;
    if (bus.sw_rst_req) begin
      ack_pend_d = 1'b1;
    end else if (state_d == ST_DONE && state_q != ST_DONE && ack_pend_q) begin
      ack_d      = 1'b1;
      ack_pend_d = 1'b0;
    end
  end

  assign bus.dom_rst_     = dom_q;
  assign bus.busy         = busy_q;
  assign bus.all_released = all_rel_q;
  assign bus.sw_rst_ack   = ack_q;

`ifdef RST_SEQ_WDOG_EN
  logic [15:0] wcnt_q;
  logic        wdog_q;

  // Watchdog: count consecutive hold cycles, latch the error until reset
  always_ff @(posedge clk) begin
    if (!rst_) begin
      wcnt_q <= '0;
      wdog_q <= 1'b0;
    end else if (bus.hold) begin
      if (wcnt_q != 16'(WDOG_CYCLES)) begin
        wcnt_q <= wcnt_q + 16'd1;
      end
      if (wcnt_q == 16'(WDOG_CYCLES - 1)) begin
        wdog_q <= 1'b1;
      end
    end else begin
      wcnt_q <= '0;
    end
  end

  assign bus.wdog_err = wdog_q;
`else
  assign bus.wdog_err = 1'b0;
`endif
endmodule

// File: tb/tb_rst_seq.sv
// tb/tb_rst_seq.sv - randomized and directed bench for rst_seq against a timeline model
module tb_rst_seq;
  localparam int N0 = 4;
  localparam int S0 = 16;
  localparam int N1 = 1;
  localparam int S1 = 2;
  localparam int W  = 8;
`ifdef RST_SEQ_WDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_;
  logic req;
  logic hold;

  always #5 clk = ~clk;

  rst_seq_if #(.NUM_DOMAINS(N0)) bus0 ();
  rst_seq_if #(.NUM_DOMAINS(N1)) bus1 ();

  assign bus0.sw_rst_req = req;
  assign bus0.hold       = hold;
  assign bus1.sw_rst_req = req;
  assign bus1.hold       = hold;

  rst_seq #(.NUM_DOMAINS(N0), .STAGE_CYCLES(S0), .WDOG_CYCLES(W)) dut0 (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus0)
  );

  rst_seq #(.NUM_DOMAINS(N1), .STAGE_CYCLES(S1), .WDOG_CYCLES(W)) dut1 (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus1)
  );

  int total = 0;
  int bad   = 0;

  // model: t = cycles of undisturbed sequencing since the last restart, capped at n*s
  int t    [2];
  bit pend [2];
  bit ack  [2];
  int wd   [2];
  bit err  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_dom(input int tt, input int n, input int s);
    int r;
    r = tt / s;
    if (r > n) r = n;
    return (32'd1 << r) - 32'd1;
  endfunction

  task automatic model_step(input int i, input int n, input int s);
    int tp;
    if (!rst_) begin
      t[i] = 0; pend[i] = 0; ack[i] = 0; wd[i] = 0; err[i] = 0;
    end else begin
      if (WD_ON) begin
        if (hold) begin
          if (wd[i] < W) wd[i]++;
          if (wd[i] == W) err[i] = 1;
        end else begin
          wd[i] = 0;
        end
      end
      if (req) begin
        t[i] = 0; pend[i] = 1; ack[i] = 0;
      end else if (hold) begin
        t[i] = 0; ack[i] = 0;
      end else begin
        tp = t[i];
        if (t[i] < n * s) t[i]++;
        ack[i] = pend[i] && tp < n * s && t[i] == n * s;
        if (ack[i]) pend[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("d0_dom",  32'(bus0.dom_rst_),     exp_dom(t[0], N0, S0));
    chk("d0_busy", 32'(bus0.busy),         32'(t[0] < N0 * S0));
    chk("d0_allr", 32'(bus0.all_released), 32'(t[0] == N0 * S0));
    chk("d0_ack",  32'(bus0.sw_rst_ack),   32'(ack[0]));
    chk("d0_wdog", 32'(bus0.wdog_err),     32'(err[0]));
    chk("d1_dom",  32'(bus1.dom_rst_),     exp_dom(t[1], N1, S1));
    chk("d1_allr", 32'(bus1.all_released), 32'(t[1] == N1 * S1));
    chk("d1_ack",  32'(bus1.sw_rst_ack),   32'(ack[1]));
  endtask

  task automatic cyc(input bit r, input bit q, input bit h);
    rst_ = r; req = q; hold = h;
    @(posedge clk);
    model_step(0, N0, S0);
    model_step(1, N1, S1);
    #1;
    check_all();
  endtask

  initial begin
    int hb;
    rst_ = 1'b0; req = 1'b0; hold = 1'b0;

    // reset values and a plain power-up sequence
    for (int c = 0; c < 3; c++) cyc(0, 0, 0);
    chk("rst_dom",  32'(bus0.dom_rst_), 32'h0);
    chk("rst_busy", 32'(bus0.busy), 32'h1);
    for (int c = 1; c <= 70; c++) begin
      cyc(1, 0, 0);
      if (c == 15) chk("pwr_c15",  32'(bus0.dom_rst_), 32'h0);
      if (c == 16) chk("pwr_c16",  32'(bus0.dom_rst_), 32'h1);
      if (c == 32) chk("pwr_c32",  32'(bus0.dom_rst_), 32'h3);
      if (c == 48) chk("pwr_c48",  32'(bus0.dom_rst_), 32'h7);
      if (c == 63) chk("pwr_c63b", 32'(bus0.busy), 32'h1);
      if (c == 64) chk("pwr_c64",  32'(bus0.all_released), 32'h1);
      if (c == 64) chk("pwr_c64b", 32'(bus0.busy), 32'h0);
      if (c == 2)  chk("n1_c2",    32'(bus1.all_released), 32'h1);
    end

    // software request pulse from DONE
    cyc(1, 1, 0);
    chk("sw_clr", 32'(bus0.dom_rst_), 32'h0);
    for (int c = 1; c <= 70; c++) begin
      cyc(1, 0, 0);
      if (c == 64) chk("sw_ack64", 32'(bus0.sw_rst_ack), 32'h1);
      if (c == 65) chk("sw_ack65", 32'(bus0.sw_rst_ack), 32'h0);
    end

    // hold mid-sequence
    cyc(0, 0, 0);
    for (int c = 1; c < 40; c++) cyc(1, 0, 0);
    for (int c = 0; c < 10; c++) begin
      cyc(1, 0, 1);
      if (c == 0) chk("hold_clr", 32'(bus0.dom_rst_), 32'h0);
    end
    for (int c = 1; c <= 70; c++) begin
      cyc(1, 0, 0);
      if (c == 16) chk("hold_b0", 32'(bus0.dom_rst_), 32'h1);
    end

    // request then reset abort: no ack afterwards
    cyc(0, 0, 0);
    for (int c = 1; c < 20; c++) cyc(1, 0, 0);
    cyc(1, 1, 0);
    for (int c = 0; c < 10; c++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    for (int c = 1; c <= 70; c++) begin
      cyc(1, 0, 0);
      if (c == 64) chk("abort_noack", 32'(bus0.sw_rst_ack), 32'h0);
    end

    // held-high request restarts each cycle, with and without hold
    for (int c = 0; c < 5; c++) cyc(1, 1, c[0]);
    for (int c = 1; c <= 66; c++) cyc(1, 0, 0);

    // watchdog
    for (int c = 1; c <= 10; c++) begin
      cyc(1, 0, 1);
      if (c == 7) chk("wd_c7", 32'(bus0.wdog_err), 32'h0);
      if (c == 8) chk("wd_c8", 32'(bus0.wdog_err), 32'(WD_ON));
    end
    for (int c = 0; c < 5; c++) cyc(1, 0, 0);
    chk("wd_sticky", 32'(bus0.wdog_err), 32'(WD_ON));
    cyc(0, 0, 0);

    // randomized traffic
    hb = 0;
    for (int k = 0; k < 3000; k++) begin
      bit r, q, h;
      r = ($urandom_range(199) != 0);
      q = ($urandom_range(39) == 0);
      if (hb > 0) begin
        h = 1'b1;
        hb--;
      end else if ($urandom_range(49) == 0) begin
        h = 1'b1;
        hb = $urandom_range(12, 1);
      end else begin
        h = 1'b0;
      end
      cyc(r, q, h);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter NUM_DOMAINS, default 4, range 1..8: number of sequenced reset domains.
REQ-002 Parameter STAGE_CYCLES, default 16, range 2..65535: clk cycles per sequencing stage.
REQ-003 Parameter WDOG_CYCLES, default 1024, range 2..65535: hold-timeout limit; used only with RST_SEQ_WDOG_EN.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_  in  1  reset, synchronous, active-low.
REQ-006 sw_rst_req  in  1  software reset request; level, sampled each cycle.
REQ-007 hold  in  1  high keeps all domains in reset.
REQ-008 dom_rst_  out  NUM_DOMAINS  active-low domain resets; bit 0 released first.
REQ-009 busy  out  1  high while the sequence is not complete.
REQ-010 all_released  out  1  high when every dom_rst_ bit is 1.
REQ-011 sw_rst_ack  out  1  one-cycle pulse on completion of a sequence started by sw_rst_req.
REQ-012 wdog_err  out  1  sticky hold-timeout flag.

Function
REQ-013 FSM states: ASSERT, RELEASE, DONE; 16-bit stage counter cnt; domain index idx.
REQ-014 ASSERT: dom_rst_ all 0, busy=1; cnt increments each cycle while hold=0; at cnt==STAGE_CYCLES-1: clear cnt, release bit 0, idx=1, go RELEASE (or DONE if NUM_DOMAINS==1).
REQ-015 ASSERT with hold=1: cnt held at 0; no state change.
REQ-016 RELEASE: cnt increments; at cnt==STAGE_CYCLES-1: clear cnt, set dom_rst_[idx]=1, idx+1; release of bit NUM_DOMAINS-1 moves to DONE on the same edge.
REQ-017 Released bits stay 1 through RELEASE; bits are released strictly in ascending order, one per stage.
REQ-018 Bit k is released exactly (k+1)*STAGE_CYCLES cycles after entry to ASSERT with hold=0 throughout.
REQ-019 DONE: all_released=1, busy=0, cnt held 0.
REQ-020 hold=1 in RELEASE or DONE: next edge all dom_rst_=0, cnt=0, idx=0, state ASSERT.
REQ-021 sw_rst_req=1 in any state: next edge all dom_rst_=0, cnt=0, idx=0, state ASSERT, ack_pending=1; a held-high request restarts every cycle.
REQ-022 sw_rst_req and hold both high: identical restart; ack_pending set.
REQ-023 sw_rst_ack=1 for exactly the one cycle following DONE entry when ack_pending=1; ack_pending clears on the same edge.
REQ-024 all_released and busy are registered; they change on the same edge as dom_rst_.

Reset
REQ-025 rst_=0 at a rising edge: state ASSERT, cnt=0, idx=0, dom_rst_ all 0, busy=1, all_released=0, sw_rst_ack=0, ack_pending=0, wdog_err=0.
REQ-026 rst_ low mid-sequence aborts at the next edge with no ack pulse; releasing rst_ restarts from ASSERT, cnt=0.

Configuration
REQ-027 Macro RST_SEQ_WDOG_EN defined: 16-bit counter counts consecutive cycles with hold=1; on reaching WDOG_CYCLES, wdog_err=1 until rst_=0; hold=0 clears the counter, not the flag.
REQ-028 Macro RST_SEQ_WDOG_EN undefined: no watchdog logic; wdog_err constant 0.

Verification
REQ-029 Defaults, rst_ low 3 cycles then high, hold=0 -> dom_rst_ bits 0..3 rise at cycles 16,32,48,64 after release; all_released=1, busy=0 at cycle 64; no ack.
REQ-030 In DONE, sw_rst_req 1-cycle pulse -> dom_rst_=4'b0000 next edge; same 16/32/48/64 schedule; sw_rst_ack single pulse one cycle after DONE re-entry.
REQ-031 hold=1 at cycle 40 for 10 cycles -> dom_rst_=4'b0000 at cycle 41; bit 0 rises 16 cycles after hold falls; no ack.
REQ-032 sw_rst_req at cycle 20 of a sequence, then rst_=0 at cycle 30 -> all outputs at reset values; after rst_ high, full sequence, no sw_rst_ack.
REQ-033 RST_SEQ_WDOG_EN, WDOG_CYCLES=8, hold high 8 cycles -> wdog_err rises on 8th cycle, stays 1 after hold drops; without macro, wdog_err stays 0.
REQ-034 NUM_DOMAINS=1, STAGE_CYCLES=2 -> dom_rst_ rises and all_released=1 two cycles after reset release.
